control_sequencer: RTL and testbench

Issue sequencer in front of the control-word mux. It accepts opcodes from the fetch stage over a valid/ready handshake and drives the mux's 4-bit selector. It registers the selected 55-bit control word into a one-deep output stage that the datapath drains with its own valid/ready handshake. After every jump it enforces a fixed flush window, and it supports a halt request that stops issue once the output stage is drained.

---
 rtl/control_sequencer.sv | 93 +++++++++
 tb/tb_control_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Issue sequencer: accepts fetch opcodes, drives the control-word mux selector and
// registers the selected word into a one-deep output stage with jump flush and halt.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | issuing; blocked only by halt or a full, undrained slot
// FLUSH  | post-jump no-issue window, flush_cnt counts down to 1
// HALTED | issue stopped until halt drops
module control_sequencer #(
    parameter int              OPCODE_W     = 4,
    parameter int              CW_W         = 55,
    parameter int              FLUSH_CYCLES = 2,
    parameter logic [OPCODE_W-1:0] JUMP_OP  = 4'hF,
    parameter logic [OPCODE_W-1:0] NULL_OP  = 4'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    input  logic [OPCODE_W-1:0] instr_opcode,
    output logic                instr_ready,
    output logic [OPCODE_W-1:0] selector,
    input  logic [CW_W-1:0]     selected_word,
    output logic [CW_W-1:0]     control_word,
    output logic                cw_valid,
    input  logic                dp_ready,
    input  logic                halt,
    output logic                halted,
    output logic [15:0]         issued_count
);

    typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t     state;
    logic [3:0] flush_cnt;
    logic       slot_free;
    logic       accept;

    assign slot_free   = !cw_valid || dp_ready;
    assign instr_ready = (state == RUN) && !halt && slot_free;
    assign accept      = instr_valid && instr_ready;
    // Selector depends only on the handshake, never on selected_word, to avoid a loop.
    assign selector    = accept ? instr_opcode : NULL_OP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            flush_cnt    <= 4'd0;
            control_word <= '0;
            cw_valid     <= 1'b0;
            issued_count <= 16'd0;
            halted       <= 1'b0;
        end else begin
            if (accept) begin
                control_word <= selected_word;
                cw_valid     <= 1'b1;
                issued_count <= issued_count + 16'd1;
            end else if (cw_valid && dp_ready) begin
                cw_valid <= 1'b0;
            end

            case (state)
                RUN: begin
                    if (accept && instr_opcode == JUMP_OP) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                    end else if (halt && !cw_valid) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt - 4'd1;
                    if (flush_cnt == 4'd1) begin
                        state <= RUN;
                    end
                end
                HALTED: begin
                    if (!halt) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: stream, backpressure, jump flush, halt,
// async reset mid-flush and issue counter wrap, against a simple mux model.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [3:0]  instr_opcode = 4'h0;
    logic        instr_ready;
    logic [3:0]  selector;
    logic [54:0] selected_word;
    logic [54:0] control_word;
    logic        cw_valid;
    logic        dp_ready = 1'b1;
    logic        halt = 1'b0;
    logic        halted;
    logic [15:0] issued_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [54:0] mux_word(input logic [3:0] s);
        return {s, 3'b101, 16'(s) * 16'h1111, 32'(s) ^ 32'hCAFE_0000};
    endfunction

    assign selected_word = mux_word(selector);

    control_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr_opcode  (instr_opcode),
        .instr_ready   (instr_ready),
        .selector      (selector),
        .selected_word (selected_word),
        .control_word  (control_word),
        .cw_valid      (cw_valid),
        .dp_ready      (dp_ready),
        .halt          (halt),
        .halted        (halted),
        .issued_count  (issued_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_cw_valid", 64'(cw_valid), 64'd0);
        chk("rst_cw", 64'(control_word), 64'd0);
        chk("rst_cnt", 64'(issued_count), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_ready", 64'(instr_ready), 64'd1);
        tick();
        rst = 1'b0;

        // Back-to-back stream 1, D, E
        instr_valid = 1'b1; instr_opcode = 4'h1;
        #1;
        chk("s_ready", 64'(instr_ready), 64'd1);
        chk("s_sel1", 64'(selector), 64'h1);
        tick();
        chk("s_cw1", 64'(control_word), 64'(mux_word(4'h1)));
        instr_opcode = 4'hD;
        tick();
        chk("s_cwD", 64'(control_word), 64'(mux_word(4'hD)));
        instr_opcode = 4'hE;
        tick();
        chk("s_cwE", 64'(control_word), 64'(mux_word(4'hE)));
        chk("s_valid", 64'(cw_valid), 64'd1);
        chk("s_cnt", 64'(issued_count), 64'd3);
        instr_valid = 1'b0;
        #1;
        chk("s_sel0", 64'(selector), 64'h0);
        tick();
        chk("s_drain", 64'(cw_valid), 64'd0);
        chk("s_keep", 64'(control_word), 64'(mux_word(4'hE)));

        // Backpressure
        instr_valid = 1'b1; instr_opcode = 4'h5;
        tick();
        dp_ready = 1'b0; instr_opcode = 4'h6;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", 64'(instr_ready), 64'd0);
            tick();
            chk("bp_cw", 64'(control_word), 64'(mux_word(4'h5)));
            chk("bp_cnt", 64'(issued_count), 64'd4);
        end
        dp_ready = 1'b1;
        #1;
        chk("bp_ready1", 64'(instr_ready), 64'd1);
        tick();
        chk("bp_cw6", 64'(control_word), 64'(mux_word(4'h6)));
        chk("bp_valid", 64'(cw_valid), 64'd1);
        chk("bp_cnt5", 64'(issued_count), 64'd5);
        instr_valid = 1'b0;
        tick();

        // Jump flush with instr_valid held
        instr_valid = 1'b1; instr_opcode = 4'hF;
        tick();
        instr_opcode = 4'h7;
        chk("j_cw", 64'(control_word), 64'(mux_word(4'hF)));
        chk("j_ready_k1", 64'(instr_ready), 64'd0);
        tick();
        chk("j_ready_k2", 64'(instr_ready), 64'd0);
        tick();
        chk("j_ready_k3", 64'(instr_ready), 64'd1);
        tick();
        chk("j_cnt", 64'(issued_count), 64'd7);
        chk("j_cw7", 64'(control_word), 64'(mux_word(4'h7)));
        instr_valid = 1'b0;
        tick();

        // Halt with a pending word under backpressure
        instr_valid = 1'b1; instr_opcode = 4'h3;
        tick();
        dp_ready = 1'b0; halt = 1'b1; instr_opcode = 4'h4;
        #1;
        chk("h_ready", 64'(instr_ready), 64'd0);
        tick();
        chk("h_halted0", 64'(halted), 64'd0);
        chk("h_cnt", 64'(issued_count), 64'd8);
        chk("h_valid", 64'(cw_valid), 64'd1);
        dp_ready = 1'b1;
        #1;
        chk("h_win", 64'(instr_ready), 64'd0);
        tick();
        chk("h_drained", 64'(cw_valid), 64'd0);
        chk("h_halted_d", 64'(halted), 64'd0);
        tick();
        chk("h_halted1", 64'(halted), 64'd1);
        halt = 1'b0;
        #1;
        chk("h_ready_h", 64'(instr_ready), 64'd0);
        tick();
        chk("h_resume", 64'(halted), 64'd0);
        chk("h_ready_r", 64'(instr_ready), 64'd1);
        tick();
        chk("h_cnt9", 64'(issued_count), 64'd9);
        chk("h_cw4", 64'(control_word), 64'(mux_word(4'h4)));
        instr_valid = 1'b0;
        tick();

        // Async reset mid-flush
        instr_valid = 1'b1; instr_opcode = 4'hF;
        tick();
        instr_valid = 1'b0;
        chk("r_cnt_pre", 64'(issued_count), 64'd10);
        #2;
        rst = 1'b1;
        #1;
        chk("r_valid", 64'(cw_valid), 64'd0);
        chk("r_cw", 64'(control_word), 64'd0);
        chk("r_cnt", 64'(issued_count), 64'd0);
        chk("r_halted", 64'(halted), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("r_ready", 64'(instr_ready), 64'd1);

        // issued_count wrap
        instr_valid = 1'b1; instr_opcode = 4'h1;
        repeat (65536) tick();
        chk("w_cnt0", 64'(issued_count), 64'd0);
        tick();
        chk("w_cnt1", 64'(issued_count), 64'd1);
        instr_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
